// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : 32-bit sequential restoring divider (signed/unsigned) that
//               borrows an external shared subtractor for its iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic        rem_sel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero,
    output logic [31:0] sub_in1,
    output logic [31:0] sub_in2,
    input  logic [31:0] sub_diff,
    input  logic        sub_carry
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_PREP  = 3'd1;
    localparam logic [2:0] c_ITER  = 3'd2;
    localparam logic [2:0] c_FIXUP = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_signed;
    logic        r_rem_sel;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic [31:0] r_d;
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [31:0] r_result;
    logic        r_div_by_zero;

    logic [31:0] w_shifted;
    logic        w_take;
    logic        w_d_zero;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_shifted = {r_r[30:0], r_q[31]};
    // R[31] set means the shifted partial remainder is a 33-bit value that
    // always exceeds the divisor, whatever the 32-bit compare says.
    assign w_take    = sub_carry | r_r[31];
    assign w_d_zero  = (r_d == 32'd0);
    assign w_q_fix   = (r_neg_q && !r_dz) ? (~r_q + 32'd1) : r_q;
    assign w_r_fix   = (r_neg_r && !r_dz) ? (~r_r + 32'd1) : r_r;

    assign result      = r_result;
    assign div_by_zero = r_div_by_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        sub_in1      = 32'd0;
        sub_in2      = 32'd0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = c_PREP;
                end
            end
            c_PREP: begin
                busy = 1'b1;
                // Zero divisor skips the iterations but still passes through
                // FIXUP, where the result register is loaded.
                w_next_state = w_d_zero ? c_FIXUP : c_ITER;
            end
            c_ITER: begin
                busy    = 1'b1;
                sub_in1 = w_shifted;
                sub_in2 = r_d;
                if (r_cnt == 5'd31) begin
                    w_next_state = c_FIXUP;
                end
            end
            c_FIXUP: begin
                busy         = 1'b1;
                w_next_state = c_DONE;
            end
            c_DONE: begin
                done         = 1'b1;
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_signed      <= 1'b0;
            r_rem_sel     <= 1'b0;
            r_q           <= 32'd0;
            r_r           <= 32'd0;
            r_d           <= 32'd0;
            r_cnt         <= 5'd0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            r_result      <= 32'd0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_signed      <= signed_op;
                        r_rem_sel     <= rem_sel;
                        r_q           <= dividend;
                        r_d           <= divisor;
                        r_div_by_zero <= 1'b0;
                    end
                end
                c_PREP: begin
                    r_cnt   <= 5'd0;
                    r_neg_q <= r_signed & (r_q[31] ^ r_d[31]);
                    r_neg_r <= r_signed & r_q[31];
                    r_dz    <= w_d_zero;
                    if (w_d_zero) begin
                        r_q <= 32'hFFFF_FFFF;
                        r_r <= r_q;
                    end else begin
                        r_r <= 32'd0;
                        r_q <= (r_signed && r_q[31]) ? (~r_q + 32'd1) : r_q;
                        r_d <= (r_signed && r_d[31]) ? (~r_d + 32'd1) : r_d;
                    end
                end
                c_ITER: begin
                    r_q   <= {r_q[30:0], w_take};
                    r_r   <= w_take ? sub_diff : w_shifted;
                    r_cnt <= r_cnt + 5'd1;
                end
                c_FIXUP: begin
                    r_result      <= r_rem_sel ? w_r_fix : w_q_fix;
                    r_div_by_zero <= r_dz;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq
// Description : Directed, table-driven self-checking bench for div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic        rem_sel;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;
    logic [31:0] sub_in1;
    logic [31:0] sub_in2;
    logic [31:0] sub_diff;
    logic        sub_carry;

    int n_pass;
    int n_total;

    // Shared subtractor model
    assign sub_diff  = sub_in1 - sub_in2;
    assign sub_carry = (sub_in1 >= sub_in2);

    div_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .rem_sel     (rem_sel),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .sub_in1     (sub_in1),
        .sub_in2     (sub_in2),
        .sub_diff    (sub_diff),
        .sub_carry   (sub_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        r;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] exp_res;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic s, input logic r, input logic [31:0] dvd, input logic [31:0] dvs);
        start     = 1'b1;
        signed_op = s;
        rem_sel   = r;
        dividend  = dvd;
        divisor   = dvs;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int n_done;
        int first_edge;
        logic [31:0] first_res;

        vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'h0000_000E, 1'b0, 34};
        vecs[1]  = '{1'b0, 1'b1, 32'd100,        32'd7,          32'h0000_0002, 1'b0, 34};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0, 34};
        vecs[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0, 34};
        vecs[4]  = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'h0000_0001, 1'b0, 34};
        vecs[5]  = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE, 1'b0, 34};
        vecs[6]  = '{1'b0, 1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 1'b1, 2};
        vecs[7]  = '{1'b1, 1'b1, 32'h1234_5678,  32'd0,          32'h1234_5678, 1'b1, 2};
        vecs[8]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0, 34};
        vecs[9]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 34};
        vecs[10] = '{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 1'b0, 34};
        vecs[11] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 1'b0, 34};
        vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 1'b0, 34};

        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        rem_sel   = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",    {31'd0, busy},        32'd0);
        check("reset_done",    {31'd0, done},        32'd0);
        check("reset_dz",      {31'd0, div_by_zero}, 32'd0);
        check("reset_result",  result,               32'd0);
        check("reset_sub_in1", sub_in1,              32'd0);
        check("reset_sub_in2", sub_in2,              32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            do_start(vecs[i].s, vecs[i].r, vecs[i].dvd, vecs[i].dvs);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            wait_done(lat);
            check($sformatf("v%0d_lat", i),    lat,                  vecs[i].exp_lat);
            check($sformatf("v%0d_result", i), result,               vecs[i].exp_res);
            check($sformatf("v%0d_dz", i),     {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dz});
            check($sformatf("v%0d_busy_done", i), {31'd0, busy},     32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse", i),  {31'd0, done},        32'd0);
            check($sformatf("v%0d_hold", i),   result,               vecs[i].exp_res);
            check($sformatf("v%0d_sub_idle", i), sub_in1 | sub_in2,  32'd0);
        end

        // start while busy is ignored
        do_start(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        rem_sel  = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        start      = 1'b0;
        n_done     = 0;
        first_edge = -1;
        first_res  = 32'd0;
        for (int e = 6; e <= 90; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (first_edge < 0) begin
                    first_edge = e;
                    first_res  = result;
                end
            end
        end
        check("busy_start_lat",    first_edge, 34);
        check("busy_start_result", first_res,  32'h0000_000E);
        check("busy_start_ndone",  n_done,     1);

        // start during DONE ignored, accepted in the following IDLE
        do_start(1'b0, 1'b0, 32'd100, 32'd7);
        wait_done(lat);
        check("done_start_lat1", lat, 34);
        start    = 1'b1;
        rem_sel  = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        check("done_start_ignored", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_start_accept", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("done_start_lat2",   lat,    34);
        check("done_start_result", result, 32'h0000_0002);
        @(posedge clk);
        #1;

        // asynchronous reset mid-operation aborts with no done
        do_start(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy",    {31'd0, busy},        32'd0);
        check("abort_done",    {31'd0, done},        32'd0);
        check("abort_dz",      {31'd0, div_by_zero}, 32'd0);
        check("abort_result",  result,               32'd0);
        check("abort_sub",     sub_in1 | sub_in2,    32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        n_done = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        do_start(1'b0, 1'b0, 32'd100, 32'd7);
        wait_done(lat);
        check("after_reset_lat",    lat,    34);
        check("after_reset_result", result, 32'h0000_000E);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
